// File: rtl/game_state_ctrl.sv
// ---------------------------------------------------------------------------
// game_state_ctrl
//
// Frame-synchronous collision and game-state controller for a scanned
// space-invaders style display. While the display timing generator walks the
// active region, pixels where a live alien sprite and a player missile
// overlap are accumulated into sticky pending masks. On the last active pixel
// of the frame everything is committed at once, so every output changes only
// at a frame boundary (or on restart/reset).
//
// There is no valid/ready handshake on this block: every input is a per-pixel
// level qualified by video_on, and every output is a register.
//
// Ports
//   vga_clk_i      pixel clock (only clock)
//   vga_rst_n_i    asynchronous active-low reset
//   video_on       active-region flag from the timing generator
//   pixel_row      current row (12 bits)
//   pixel_column   current column (12 bits)
//   alien_active   per-alien "sprite covers this pixel" flags
//   missle_active  per-missile "sprite covers this pixel" flags
//   landed         OR of the alien-reached-bottom flags
//   restart        player restart request (level, honoured in WIN/LOSE only)
//   alien_alive    registered alive mask
//   missle_hit     one-cycle per-missile retire pulse, valid with frame_commit
//   game_state     FSM state: 00 PLAY, 01 WIN, 10 LOSE
//   kill_count     number of dead aliens, saturating at 15
//   frame_commit   one-cycle pulse on the cycle after the last active pixel
// ---------------------------------------------------------------------------
module game_state_ctrl #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int N_ALIENS  = 15,
  parameter int N_MISSLES = 8
) (
  input  logic                 vga_clk_i,
  input  logic                 vga_rst_n_i,
  input  logic                 video_on,
  input  logic [11:0]          pixel_row,
  input  logic [11:0]          pixel_column,
  input  logic [N_ALIENS-1:0]  alien_active,
  input  logic [N_MISSLES-1:0] missle_active,
  input  logic                 landed,
  input  logic                 restart,
  output logic [N_ALIENS-1:0]  alien_alive,
  output logic [N_MISSLES-1:0] missle_hit,
  output logic [1:0]           game_state,
  output logic [3:0]           kill_count,
  output logic                 frame_commit
);

  typedef enum logic [1:0] {
    ST_PLAY = 2'b00,
    ST_WIN  = 2'b01,
    ST_LOSE = 2'b10
  } state_t;

  localparam logic [11:0] LAST_ROW = 12'(V_ACTIVE - 1);
  localparam logic [11:0] LAST_COL = 12'(H_ACTIVE - 1);

  state_t               state;
  logic [N_ALIENS-1:0]  pending_kill;
  logic [N_MISSLES-1:0] pending_miss;
  logic                 pending_land;

  logic                 in_play;
  logic                 scan_hit;
  logic                 frame_end;
  logic [N_ALIENS-1:0]  kill_now;
  logic [N_MISSLES-1:0] miss_now;
  logic                 land_now;
  logic [N_ALIENS-1:0]  kill_all;
  logic [N_MISSLES-1:0] miss_all;
  logic                 land_all;
  logic [N_ALIENS-1:0]  next_alive;
  logic [7:0]           kill_sum;
  logic [3:0]           kill_next;

  function automatic logic [7:0] popcount(input logic [N_ALIENS-1:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < N_ALIENS; i++) n = n + 8'(v[i]);
    return n;
  endfunction

  // The state register doubles as the observable FSM state.
  assign game_state = state;

  always_comb begin
    in_play   = (state == ST_PLAY);
    scan_hit  = video_on && in_play && ((alien_active & alien_alive) != '0)
                && (missle_active != '0);
    frame_end = video_on && (pixel_row == LAST_ROW) && (pixel_column == LAST_COL);
    kill_now  = scan_hit ? (alien_active & alien_alive) : '0;
    miss_now  = scan_hit ? missle_active : '0;
    land_now  = landed && video_on && in_play;
    // The frame-end pixel's own contributions are folded into the commit.
    kill_all   = pending_kill | kill_now;
    miss_all   = pending_miss | miss_now;
    land_all   = pending_land | land_now;
    next_alive = alien_alive & ~kill_all;
    kill_sum   = 8'(kill_count) + popcount(kill_all & alien_alive);
    kill_next  = (kill_sum > 8'd15) ? 4'd15 : kill_sum[3:0];
  end

  always_ff @(posedge vga_clk_i or negedge vga_rst_n_i) begin
    if (!vga_rst_n_i) begin
      state        <= ST_PLAY;
      alien_alive  <= '1;
      missle_hit   <= '0;
      kill_count   <= '0;
      frame_commit <= 1'b0;
      pending_kill <= '0;
      pending_miss <= '0;
      pending_land <= 1'b0;
    end else begin
      // frame_commit is the registered frame-end flag; it pulses in every
      // state, and missle_hit is a single-cycle pulse by default.
      frame_commit <= frame_end;
      missle_hit   <= '0;
      case (state)
        ST_PLAY: begin
          if (frame_end) begin
            alien_alive  <= next_alive;
            missle_hit   <= miss_all;
            kill_count   <= kill_next;
            pending_kill <= '0;
            pending_miss <= '0;
            pending_land <= 1'b0;
            // Landing beats clearing the last alien in the same frame.
            if (land_all)                state <= ST_LOSE;
            else if (next_alive == '0)   state <= ST_WIN;
          end else begin
            pending_kill <= kill_all;
            pending_miss <= miss_all;
            pending_land <= land_all;
          end
        end
        default: begin
          // WIN / LOSE: scan activity is gated off by in_play, so the
          // pending registers stay clear; only restart leaves this state.
          pending_kill <= '0;
          pending_miss <= '0;
          pending_land <= 1'b0;
          if (restart) begin
            state       <= ST_PLAY;
            alien_alive <= '1;
            kill_count  <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_state_ctrl
//
// Directed bench for game_state_ctrl. Pixel coordinates are driven directly,
// so a "frame" is a handful of interesting pixels followed by the last active
// pixel (479,639). Outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_game_state_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        video_on;
  logic [11:0] pixel_row;
  logic [11:0] pixel_column;
  logic [14:0] alien_active;
  logic [7:0]  missle_active;
  logic        landed;
  logic        restart;
  logic [14:0] alien_alive;
  logic [7:0]  missle_hit;
  logic [1:0]  game_state;
  logic [3:0]  kill_count;
  logic        frame_commit;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] PLAY = 2'b00;
  localparam logic [1:0] WIN  = 2'b01;
  localparam logic [1:0] LOSE = 2'b10;

  game_state_ctrl #(
    .H_ACTIVE(640), .V_ACTIVE(480), .N_ALIENS(15), .N_MISSLES(8)
  ) dut (
    .vga_clk_i     (clk),
    .vga_rst_n_i   (rst_n),
    .video_on      (video_on),
    .pixel_row     (pixel_row),
    .pixel_column  (pixel_column),
    .alien_active  (alien_active),
    .missle_active (missle_active),
    .landed        (landed),
    .restart       (restart),
    .alien_alive   (alien_alive),
    .missle_hit    (missle_hit),
    .game_state    (game_state),
    .kill_count    (kill_count),
    .frame_commit  (frame_commit)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic set_idle();
    video_on = 1'b0; pixel_row = '0; pixel_column = '0;
    alien_active = '0; missle_active = '0; landed = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    restart = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- drivers ----------------
  // Present one pixel for one clock, then return inputs to idle.
  task automatic step(input logic vo, input logic [11:0] r, input logic [11:0] c,
                      input logic [14:0] a, input logic [7:0] m, input logic l);
    video_on = vo; pixel_row = r; pixel_column = c;
    alien_active = a; missle_active = m; landed = l;
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic end_frame(input logic [14:0] a, input logic [7:0] m, input logic l);
    step(1'b1, 12'd479, 12'd639, a, m, l);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; set_idle(); restart = 1'b0;
    repeat (2) @(posedge clk); #1;
    total++; if (alien_alive !== 15'h7FFF) begin bad++; $display("FAIL reset_alive got=%h want=7fff", alien_alive); end
    total++; if (missle_hit !== 8'h00) begin bad++; $display("FAIL reset_missle_hit got=%h want=00", missle_hit); end
    total++; if (game_state !== PLAY) begin bad++; $display("FAIL reset_state got=%b want=00", game_state); end
    total++; if (kill_count !== 4'd0) begin bad++; $display("FAIL reset_kill got=%0d want=0", kill_count); end
    total++; if (frame_commit !== 1'b0) begin bad++; $display("FAIL reset_commit got=%b want=0", frame_commit); end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_hit();
    do_reset();
    step(1'b1, 12'd100, 12'd50, 15'h0080, 8'h04, 1'b0);
    total++; if (alien_alive !== 15'h7FFF) begin bad++; $display("FAIL single_before_commit got=%h want=7fff", alien_alive); end
    end_frame('0, '0, 1'b0);
    total++; if (frame_commit !== 1'b1) begin bad++; $display("FAIL single_commit got=%b want=1", frame_commit); end
    total++; if (alien_alive !== 15'h7F7F) begin bad++; $display("FAIL single_alive got=%h want=7f7f", alien_alive); end
    total++; if (missle_hit !== 8'h04) begin bad++; $display("FAIL single_missle got=%h want=04", missle_hit); end
    total++; if (kill_count !== 4'd1) begin bad++; $display("FAIL single_kill got=%0d want=1", kill_count); end
    step(1'b0, '0, '0, '0, '0, 1'b0);
    total++; if (frame_commit !== 1'b0) begin bad++; $display("FAIL single_commit_drop got=%b want=0", frame_commit); end
    total++; if (missle_hit !== 8'h00) begin bad++; $display("FAIL single_missle_drop got=%h want=00", missle_hit); end
    // A missile over only the now-dead alien 7 is not a hit.
    step(1'b1, 12'd100, 12'd50, 15'h0080, 8'h02, 1'b0);
    end_frame('0, '0, 1'b0);
    total++; if (missle_hit !== 8'h00) begin bad++; $display("FAIL dead_alien_missle got=%h want=00", missle_hit); end
    total++; if (kill_count !== 4'd1) begin bad++; $display("FAIL dead_alien_kill got=%0d want=1", kill_count); end
  endtask

  task automatic test_repeat_overlap();
    int hit_cycles;
    do_reset();
    for (int c = 50; c < 70; c++) step(1'b1, 12'd100, 12'(c), 15'h0080, 8'h01, 1'b0);
    total++; if (alien_alive !== 15'h7FFF) begin bad++; $display("FAIL repeat_before_commit got=%h want=7fff", alien_alive); end
    end_frame('0, '0, 1'b0);
    total++; if (kill_count !== 4'd1) begin bad++; $display("FAIL repeat_kill got=%0d want=1", kill_count); end
    total++; if (missle_hit !== 8'h01) begin bad++; $display("FAIL repeat_missle got=%h want=01", missle_hit); end
    hit_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0, '0, '0, 1'b0);
      if (missle_hit != 8'h00) hit_cycles++;
    end
    total++; if (hit_cycles !== 0) begin bad++; $display("FAIL repeat_missle_extra got=%0d want=0", hit_cycles); end
    // Hit on the frame-end pixel itself is part of that frame's commit.
    end_frame(15'h0001, 8'h10, 1'b0);
    total++; if (alien_alive !== 15'h7F7E) begin bad++; $display("FAIL endpix_alive got=%h want=7f7e", alien_alive); end
    total++; if (missle_hit !== 8'h10) begin bad++; $display("FAIL endpix_missle got=%h want=10", missle_hit); end
    total++; if (kill_count !== 4'd2) begin bad++; $display("FAIL endpix_kill got=%0d want=2", kill_count); end
  endtask

  task automatic test_win_restart();
    do_reset();
    step(1'b1, 12'd50, 12'd10, 15'h001F, 8'h01, 1'b0);  // five aliens on one pixel
    end_frame('0, '0, 1'b0);
    total++; if (kill_count !== 4'd5) begin bad++; $display("FAIL win_f1_kill got=%0d want=5", kill_count); end
    total++; if (game_state !== PLAY) begin bad++; $display("FAIL win_f1_state got=%b want=00", game_state); end
    step(1'b1, 12'd60, 12'd20, 15'h03E0, 8'h02, 1'b0);
    end_frame('0, '0, 1'b0);
    total++; if (alien_alive !== 15'h7C00) begin bad++; $display("FAIL win_f2_alive got=%h want=7c00", alien_alive); end
    step(1'b1, 12'd70, 12'd30, 15'h7C00, 8'h80, 1'b0);
    end_frame('0, '0, 1'b0);
    total++; if (game_state !== WIN) begin bad++; $display("FAIL win_state got=%b want=01", game_state); end
    total++; if (kill_count !== 4'd15) begin bad++; $display("FAIL win_kill got=%0d want=15", kill_count); end
    total++; if (missle_hit !== 8'h80) begin bad++; $display("FAIL win_missle got=%h want=80", missle_hit); end
    pulse_restart();
    total++; if (game_state !== PLAY) begin bad++; $display("FAIL restart_state got=%b want=00", game_state); end
    total++; if (alien_alive !== 15'h7FFF) begin bad++; $display("FAIL restart_alive got=%h want=7fff", alien_alive); end
    total++; if (kill_count !== 4'd0) begin bad++; $display("FAIL restart_kill got=%0d want=0", kill_count); end
    // restart has no effect while playing.
    step(1'b1, 12'd80, 12'd40, 15'h0001, 8'h01, 1'b0);
    end_frame('0, '0, 1'b0);
    pulse_restart();
    total++; if (kill_count !== 4'd1) begin bad++; $display("FAIL restart_play_kill got=%0d want=1", kill_count); end
    total++; if (alien_alive !== 15'h7FFE) begin bad++; $display("FAIL restart_play_alive got=%h want=7ffe", alien_alive); end
  endtask

  task automatic test_lose_priority();
    do_reset();
    step(1'b1, 12'd50, 12'd10, 15'h3FFF, 8'h01, 1'b0);
    end_frame('0, '0, 1'b0);
    total++; if (kill_count !== 4'd14) begin bad++; $display("FAIL lose_f1_kill got=%0d want=14", kill_count); end
    step(1'b1, 12'd150, 12'd10, 15'h4000, 8'h01, 1'b0);
    step(1'b1, 12'd300, 12'd10, 15'h0000, 8'h00, 1'b1);
    end_frame('0, '0, 1'b0);
    total++; if (game_state !== LOSE) begin bad++; $display("FAIL lose_state got=%b want=10", game_state); end
    total++; if (alien_alive !== 15'h0000) begin bad++; $display("FAIL lose_alive got=%h want=0000", alien_alive); end
  endtask

  task automatic test_ignore_in_lose();
    do_reset();
    step(1'b1, 12'd200, 12'd5, '0, '0, 1'b1);
    end_frame('0, '0, 1'b0);
    total++; if (game_state !== LOSE) begin bad++; $display("FAIL land_state got=%b want=10", game_state); end
    step(1'b1, 12'd100, 12'd50, 15'h0001, 8'h01, 1'b1);
    end_frame(15'h0002, 8'h02, 1'b0);
    total++; if (frame_commit !== 1'b1) begin bad++; $display("FAIL lose_commit got=%b want=1", frame_commit); end
    total++; if (missle_hit !== 8'h00) begin bad++; $display("FAIL lose_missle got=%h want=00", missle_hit); end
    total++; if (alien_alive !== 15'h7FFF) begin bad++; $display("FAIL lose_hit_alive got=%h want=7fff", alien_alive); end
    pulse_restart();
    total++; if (game_state !== PLAY) begin bad++; $display("FAIL lose_restart got=%b want=00", game_state); end
  endtask

  task automatic test_video_off();
    do_reset();
    step(1'b0, 12'd100, 12'd50, 15'h0080, 8'h01, 1'b0);
    step(1'b0, 12'd120, 12'd60, 15'h0000, 8'h00, 1'b1);
    step(1'b0, 12'd479, 12'd639, 15'h0000, 8'h00, 1'b0);
    total++; if (frame_commit !== 1'b0) begin bad++; $display("FAIL vidoff_commit got=%b want=0", frame_commit); end
    end_frame('0, '0, 1'b0);
    total++; if (alien_alive !== 15'h7FFF) begin bad++; $display("FAIL vidoff_alive got=%h want=7fff", alien_alive); end
    total++; if (missle_hit !== 8'h00) begin bad++; $display("FAIL vidoff_missle got=%h want=00", missle_hit); end
    total++; if (game_state !== PLAY) begin bad++; $display("FAIL vidoff_state got=%b want=00", game_state); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    step(1'b1, 12'd200, 12'd50, 15'h0008, 8'h02, 1'b0);
    step(1'b1, 12'd300, 12'd0, '0, '0, 1'b0);
    rst_n = 1'b0;
    #2;
    total++; if (alien_alive !== 15'h7FFF) begin bad++; $display("FAIL midrst_alive_in_reset got=%h want=7fff", alien_alive); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    end_frame('0, '0, 1'b0);
    total++; if (alien_alive !== 15'h7FFF) begin bad++; $display("FAIL midrst_alive got=%h want=7fff", alien_alive); end
    total++; if (kill_count !== 4'd0) begin bad++; $display("FAIL midrst_kill got=%0d want=0", kill_count); end
    total++; if (missle_hit !== 8'h00) begin bad++; $display("FAIL midrst_missle got=%h want=00", missle_hit); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_hit();
    test_repeat_overlap();
    test_win_restart();
    test_lose_priority();
    test_ignore_in_lose();
    test_video_off();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, 640, last active column + 1.
REQ-002 SHALL have parameter V_ACTIVE, 480, last active row + 1.
REQ-003 SHALL have parameter N_ALIENS, 15, alien sprite count (5 each of models A, B, C, ordered A1..A5, B1..B5, C1..C5).
REQ-004 SHALL have parameter N_MISSLES, 8, player missile count.
REQ-005 SHALL have port vga_clk_i  in  1  pixel clock; the only clock.
REQ-006 SHALL have port vga_rst_n_i  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port video_on  in  1  display timing active-region flag.
REQ-008 SHALL have port pixel_row  in  12  current row from display timing generator.
REQ-009 SHALL have port pixel_column  in  12  current column from display timing generator.
REQ-010 SHALL have port alien_active  in  N_ALIENS  per-alien "sprite covers this pixel" flags.
REQ-011 SHALL have port missle_active  in  N_MISSLES  per-missile "sprite covers this pixel" flags.
REQ-012 SHALL have port landed  in  1  OR of alien-reached-bottom flags.
REQ-013 SHALL have port restart  in  1  player restart request (level).
REQ-014 SHALL have port alien_alive  out  N_ALIENS  registered alive mask, consumed by the video output mux.
REQ-015 SHALL have port missle_hit  out  N_MISSLES  one-cycle per-missile retire pulse.
REQ-016 SHALL have port game_state  out  2  00 PLAY, 01 WIN, 10 LOSE.
REQ-017 SHALL have port kill_count  out  4  number of dead aliens, 0..15.
REQ-018 SHALL have port frame_commit  out  1  one-cycle end-of-frame pulse.

Function
REQ-019 SHALL define scan_hit as video_on && game_state==PLAY && (alien_active & alien_alive) != 0 && missle_active != 0.
REQ-020 On scan_hit, SHALL set pending_kill[i] for every alive active alien i and pending_miss[j] for every active missile j; bits are sticky until commit.
REQ-021 SHALL latch pending_land when landed is high, video_on is high, and game_state==PLAY.
REQ-022 SHALL detect frame end when video_on && pixel_row==V_ACTIVE-1 && pixel_column==H_ACTIVE-1, and SHALL assert frame_commit on the next cycle for exactly one cycle.
REQ-023 On the frame-end cycle, SHALL include that cycle's own scan_hit and landed contributions in the commit.
REQ-024 At commit (registered, same cycle as frame_commit), SHALL set alien_alive to alien_alive & ~pending_kill.
REQ-025 At commit, SHALL pulse missle_hit to pending_miss for one cycle.
REQ-026 At commit, SHALL increment kill_count by popcount(pending_kill & alien_alive); kill_count never exceeds 15.
REQ-027 At commit, SHALL clear all pending registers.
REQ-028 Outputs SHALL not change between commits except through restart or reset; latency from the first hit pixel to the alien_alive update is therefore at most one frame.
REQ-029 FSM PLAY -> LOSE at commit if pending_land is set; LOSE SHALL take priority over WIN when both occur in the same frame.
REQ-030 FSM PLAY -> WIN at commit if the post-commit alien_alive == 0 and pending_land is clear.
REQ-031 FSM WIN or LOSE -> PLAY on the cycle after restart is sampled high; the same edge SHALL set alien_alive to all ones, kill_count to 0, and clear all pending registers.
REQ-032 restart SHALL be ignored in PLAY.
REQ-033 In WIN or LOSE, scan_hit and landed SHALL be ignored, and frame_commit SHALL still pulse with missle_hit = 0.
REQ-034 Multiple aliens overlapping the same pixel with a missile SHALL all be killed; there is no priority encoding.
REQ-035 A missile overlapping only dead aliens SHALL not be reported in missle_hit.

Reset
REQ-036 While vga_rst_n_i is low, outputs SHALL be: alien_alive=15'h7FFF, missle_hit=0, game_state=PLAY, kill_count=0, frame_commit=0; all pending registers and the frame-end flag SHALL be cleared.
REQ-037 Assertion of reset mid-frame SHALL discard pending hits; the first commit after release SHALL reflect only hits scanned after release.

Verification
REQ-038 The bench SHALL cover: missile overlaps alien index 7 at row 100 in frame 1 -> at the cycle after (479,639): frame_commit=1, alien_alive=15'h7F7F, missle_hit shows the overlapping missile bit, kill_count=1.
REQ-039 The bench SHALL cover: the same overlap repeated for 20 pixels in one frame -> exactly one commit update, kill_count=1, missle_hit asserted for one cycle only.
REQ-040 The bench SHALL cover: all 15 aliens hit over 3 frames -> game_state=WIN after the 3rd commit, kill_count=15; restart high for 1 cycle -> PLAY, alien_alive=15'h7FFF, kill_count=0.
REQ-041 The bench SHALL cover: landed high plus the last alien hit in the same frame -> game_state=LOSE, not WIN.
REQ-042 The bench SHALL cover: hit pixel at row 200 then vga_rst_n_i low at row 300 -> after release, the next commit leaves alien_alive=15'h7FFF and kill_count=0.
REQ-043 The bench SHALL cover: hits presented with video_on=0, and hits presented while in LOSE -> no change to alien_alive and missle_hit=0.
